// File: rtl/pacman_soc_otg_hpi_master.sv
// -----------------------------------------------------------------------------
// pacman_soc_otg_hpi_master
//
// Hardware HPI bus-cycle sequencer for the CY7C67200 OTG controller. It accepts
// one 16-bit Avalon-MM read or write at a time. It plays out a timed HPI cycle
// on the chip pins: setup, then strobe, then hold. The Avalon master is stalled
// with waitrequest until the cycle has finished.
//
// Parameters:
//   SETUP_CYCLES  (1..15) clk cycles cs_n/address/data valid before the strobe
//   STROBE_CYCLES (1..15) clk cycles rd_n/wr_n held low
//   HOLD_CYCLES   (1..15) clk cycles cs_n/address/data held after the strobe
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address[1:0]        Avalon word address -> HPI A[1:0]
//   chipselect/read/write, writedata[15:0]   Avalon request
//   readdata[15:0]      read result, valid when waitrequest drops on a read
//   waitrequest         Avalon stall (combinational)
//   otg_addr[1:0]       HPI address
//   otg_data_in[15:0]   HPI data from the pad
//   otg_data_out[15:0]  HPI data to the pad
//   otg_data_oe         pad drive enable (1 = drive otg_data_out)
//   otg_cs_n, otg_rd_n, otg_wr_n   HPI strobes, active low
//
// Optional build macro OTG_HPI_IRQ_EN adds:
//   otg_int (in)  asynchronous active-high interrupt from the chip
//   irq     (out) otg_int after a 2-flop synchronizer
// -----------------------------------------------------------------------------
module pacman_soc_otg_hpi_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  input  logic [15:0] otg_data_in,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n
`ifdef OTG_HPI_IRQ_EN
  ,
  input  logic        otg_int,
  output logic        irq
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        op_write_reg, op_write_next;
  logic        latch_req;
  logic        capture_rd;
  logic        request;
  logic        active_next;
  logic        cs_n_next, rd_n_next, wr_n_next, oe_next;

  // A simultaneous read+write is treated as a write.
  assign request     = chipselect & (read | write);
  assign waitrequest = request & (state_reg != DONE);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_write_next = op_write_reg;
    latch_req     = 1'b0;
    capture_rd    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          state_next    = SETUP;
          cnt_next      = SETUP_LOAD;
          op_write_next = write;
          latch_req     = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LOAD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 4'd0) begin
          capture_rd = ~op_write_reg;
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Pin values are derived from the next state and registered, so each pin
    // changes on the same edge the FSM enters the corresponding phase and no
    // decode glitches reach the chip.
    active_next = (state_next == SETUP) || (state_next == STROBE) ||
                  (state_next == HOLD);
    cs_n_next   = ~active_next;
    rd_n_next   = ~((state_next == STROBE) & ~op_write_next);
    wr_n_next   = ~((state_next == STROBE) &  op_write_next);
    oe_next     = active_next & op_write_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      op_write_reg <= 1'b0;
      otg_addr     <= 2'd0;
      otg_data_out <= 16'd0;
      readdata     <= 16'd0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_oe  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_write_reg <= op_write_next;
      if (latch_req) begin
        otg_addr     <= address;
        otg_data_out <= writedata;
      end
      // Sample the pad on the last strobe cycle, when the chip's read data
      // has had the full strobe width to settle.
      if (capture_rd) begin
        readdata <= otg_data_in;
      end
      otg_cs_n    <= cs_n_next;
      otg_rd_n    <= rd_n_next;
      otg_wr_n    <= wr_n_next;
      otg_data_oe <= oe_next;
    end
  end

`ifdef OTG_HPI_IRQ_EN
  logic irq_meta_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_meta_reg <= 1'b0;
      irq          <= 1'b0;
    end else begin
      irq_meta_reg <= otg_int;
      irq          <= irq_meta_reg;
    end
  end
`endif

endmodule

// File: tb/tb_pacman_soc_otg_hpi_master.sv
// -----------------------------------------------------------------------------
// Bench for pacman_soc_otg_hpi_master. Two instances: index 0 uses the default
// timing (1/4/1), index 1 uses SETUP=2, STROBE=1, HOLD=3. The expected pin
// behaviour for every cycle of an access is computed from the phase lengths:
// cycle 0 = request seen, 1..S setup, S+1..S+T strobe, ..S+T+H hold, then done.
// -----------------------------------------------------------------------------
module tb_pacman_soc_otg_hpi_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic [1:0]  cs_in;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] otg_data_in;

  logic [15:0] rdata_o [2];
  logic [1:0]  wait_o;
  logic [1:0]  addr_o  [2];
  logic [15:0] dout_o  [2];
  logic [1:0]  oe_o;
  logic [1:0]  cs_n_o;
  logic [1:0]  rd_n_o;
  logic [1:0]  wr_n_o;
`ifdef OTG_HPI_IRQ_EN
  logic        otg_int;
  logic [1:0]  irq_o;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_rd [2];

  always #5 clk = ~clk;

  pacman_soc_otg_hpi_master dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_in[0]),
    .read(read), .write(write), .writedata(writedata), .readdata(rdata_o[0]),
    .waitrequest(wait_o[0]), .otg_addr(addr_o[0]), .otg_data_in(otg_data_in),
    .otg_data_out(dout_o[0]), .otg_data_oe(oe_o[0]), .otg_cs_n(cs_n_o[0]),
    .otg_rd_n(rd_n_o[0]), .otg_wr_n(wr_n_o[0])
`ifdef OTG_HPI_IRQ_EN
    , .otg_int(otg_int), .irq(irq_o[0])
`endif
  );

  pacman_soc_otg_hpi_master #(
    .SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_in[1]),
    .read(read), .write(write), .writedata(writedata), .readdata(rdata_o[1]),
    .waitrequest(wait_o[1]), .otg_addr(addr_o[1]), .otg_data_in(otg_data_in),
    .otg_data_out(dout_o[1]), .otg_data_oe(oe_o[1]), .otg_cs_n(cs_n_o[1]),
    .otg_rd_n(rd_n_o[1]), .otg_wr_n(wr_n_o[1])
`ifdef OTG_HPI_IRQ_EN
    , .otg_int(otg_int), .irq(irq_o[1])
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access on instance sel; called just after a rising edge. Leaves
  // the request asserted so a following call is a back-to-back access.
  task automatic access(input int sel, input int s, input int t, input int h,
                        input bit wr, input logic [1:0] a, input logic [15:0] wd);
    int          d;
    bit          act;
    bit          strb;
    logic [15:0] cap;
    d   = s + t + h + 1;
    cap = 16'd0;
    cs_in[sel] = 1'b1;
    write      = wr;
    read       = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    address    = a;
    writedata  = wd;
    for (int c = 0; c <= d; c++) begin
      otg_data_in = 16'($urandom);
      if (c == s + t) cap = otg_data_in;
      @(negedge clk);
      act  = (c >= 1) && (c <= s + t + h);
      strb = (c > s) && (c <= s + t);
      chk($sformatf("cs_n d%0d c%0d", sel, c), {15'd0, cs_n_o[sel]}, {15'd0, !act});
      chk($sformatf("rd_n d%0d c%0d", sel, c), {15'd0, rd_n_o[sel]}, {15'd0, !(strb && !wr)});
      chk($sformatf("wr_n d%0d c%0d", sel, c), {15'd0, wr_n_o[sel]}, {15'd0, !(strb && wr)});
      chk($sformatf("oe d%0d c%0d", sel, c), {15'd0, oe_o[sel]}, {15'd0, act && wr});
      chk($sformatf("waitreq d%0d c%0d", sel, c), {15'd0, wait_o[sel]}, {15'd0, c != d});
      if (act) begin
        chk($sformatf("otg_addr d%0d c%0d", sel, c), {14'd0, addr_o[sel]}, {14'd0, a});
        if (wr) chk($sformatf("otg_data_out d%0d c%0d", sel, c), dout_o[sel], wd);
      end
      if (c == d) begin
        if (!wr) exp_rd[sel] = cap;
        chk($sformatf("readdata d%0d", sel), rdata_o[sel], exp_rd[sel]);
      end
      @(posedge clk);
      #1;
    end
    $display("[TB] txn dut=%0d %s addr=%0d wdata=%h readdata=%h", sel,
             wr ? "WR" : "RD", a, wd, rdata_o[sel]);
  endtask

  task automatic idle(input int n);
    cs_in = 2'b00;
    read  = 1'b0;
    write = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle cs_n", {14'd0, cs_n_o}, 16'h0003);
      chk("idle waitreq", {14'd0, wait_o}, 16'h0000);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    cs_in       = 2'b00;
    read        = 1'b0;
    write       = 1'b0;
    address     = 2'd0;
    writedata   = 16'd0;
    otg_data_in = 16'd0;
    exp_rd[0]   = 16'd0;
    exp_rd[1]   = 16'd0;
`ifdef OTG_HPI_IRQ_EN
    otg_int     = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst cs_n", {14'd0, cs_n_o}, 16'h0003);
    chk("rst rd_n", {14'd0, rd_n_o}, 16'h0003);
    chk("rst wr_n", {14'd0, wr_n_o}, 16'h0003);
    chk("rst oe", {14'd0, oe_o}, 16'h0000);
    chk("rst waitreq", {14'd0, wait_o}, 16'h0000);
    chk("rst otg_addr", {14'd0, addr_o[0]}, 16'h0000);
    chk("rst otg_data_out", dout_o[0], 16'h0000);
    chk("rst readdata", rdata_o[0], 16'h0000);
`ifdef OTG_HPI_IRQ_EN
    chk("rst irq", {14'd0, irq_o}, 16'h0000);
    otg_int = 1'b0;
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed write, then two back-to-back reads with the request held
    access(0, 1, 4, 1, 1'b1, 2'd2, 16'h1234);
    access(0, 1, 4, 1, 1'b0, 2'd0, 16'h0000);
    access(0, 1, 4, 1, 1'b0, 2'd3, 16'h0000);
    idle(2);

    // Randomized traffic on the default-timing instance
    for (int n = 0; n < 20; n++) begin
      access(0, 1, 4, 1, 1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // Non-default timing instance
    access(1, 2, 1, 3, 1'b1, 2'd1, 16'hA5C3);
    access(1, 2, 1, 3, 1'b0, 2'd2, 16'h0000);
    for (int n = 0; n < 4; n++) begin
      access(1, 2, 1, 3, 1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom));
    end
    idle(2);

    // Asynchronous reset during the strobe phase of a write
    cs_in[0]  = 1'b1;
    write     = 1'b1;
    read      = 1'b0;
    address   = 2'd1;
    writedata = 16'h5A5A;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst cs_n", {15'd0, cs_n_o[0]}, 16'h0001);
    chk("async rst rd_n", {15'd0, rd_n_o[0]}, 16'h0001);
    chk("async rst wr_n", {15'd0, wr_n_o[0]}, 16'h0001);
    chk("async rst oe", {15'd0, oe_o[0]}, 16'h0000);
    chk("async rst readdata", rdata_o[0], 16'h0000);
    exp_rd[0] = 16'd0;
    exp_rd[1] = 16'd0;
    cs_in = 2'b00;
    write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    access(0, 1, 4, 1, 1'b1, 2'd3, 16'hC0DE);
    access(0, 1, 4, 1, 1'b0, 2'd0, 16'h0000);
    idle(2);

`ifdef OTG_HPI_IRQ_EN
    // Interrupt pulse of 5 cycles appears on irq 2 cycles later for 5 cycles
    for (int c = 0; c < 10; c++) begin
      otg_int = (c < 5);
      @(negedge clk);
      chk($sformatf("irq c%0d", c), {15'd0, irq_o[0]}, {15'd0, (c >= 2) && (c < 7)});
      @(posedge clk);
      #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
